dma_ctrl: RTL and testbench
===========================

# dma_ctrl

Memory-to-memory DMA engine and bus scheduler for the v65C02 system bus. It takes the single CPU address/data bus away from the 65C02 by pulling RDY low, then performs block copies or fills, for example ROM→RAM or RAM→VRAM at $8000. It returns the bus in bounded bursts so the CPU keeps running between them. It sits in the top level next to the address decoder: control registers are decoded at $A000–$A007, and the top muxes address, WE and data-out onto the shared bus whenever `bus_own_o` is high.

## Interface
- `BURST_LEN`, 16: bytes transferred per bus tenure (1–255).
- `CPU_SLOTS`, 4: CPU cycles with RDY high between bursts (≥1).
- `clk_i` in 1: CPU clock.
- `rst_i` in 1: reset, synchronous, active-high.
- `ctrl_en_i` in 1: register select, from the top decoder (addr == $A00x).
- `we_i` in 1: CPU write enable.
- `addr_i` in 3: register index.
- `din_i` in 8: CPU write data.
- `dout_o` out 8: register read data, registered (1-cycle, matching the top's pipelined read mux).
- `cpu_we_i` in 1: CPU WE, observed for safe bus takeover.
- `cpu_rdy_o` out 1: to CPU RDY.
- `bus_own_o` out 1: top drives `bus_addr_o`/`bus_we_o`/`bus_dout_o` instead of the CPU.
- `bus_addr_o` out 16, `bus_we_o` out 1, `bus_dout_o` out 8: DMA bus master outputs.
- `bus_din_i` in 8: top's read-mux output (data for the address presented in the previous cycle).
- `irq_o` out 1: level interrupt, done & irq_en.

## Operation
- Registers:
  - 0 SRC_LO, 1 SRC_HI, 2 DST_LO, 3 DST_HI, 4 LEN_LO, 5 LEN_HI.
  - 6 CTRL:
    - W: bit0 start, bit1 fill, bit2 abort, bit3 irq_en.
    - R: bit0 busy, bit1 done, bit2 aborted, bit3 irq_en.
  - 7 FILL: fill byte.
- SRC/DST/LEN are live. Readback shows the next address and the remaining count.
- Writes to regs 0–5 and 7 are ignored while busy.
- A CTRL read clears done and aborted. A CTRL write with start set also clears them.
- States:
  - IDLE: rdy=1, own=0. A CTRL write with bit0=1 goes to DONE if LEN==0, else to SYNC.
  - SYNC: rdy=0, own=0. Stay while `cpu_we_i`=1, since the CPU repeats its held write idempotently. Otherwise go to READ, or to WRITE in fill mode.
  - READ: own=1, addr=SRC, we=0. Then go to WRITE.
  - WRITE: own=1, addr=DST, we=1, dout = fill ? FILL : `bus_din_i`.
    - Then DST+=1, LEN-=1, and SRC+=1 unless fill.
    - If LEN becomes 0, go to RESTORE→DONE.
    - Else if burst count == BURST_LEN, go to RESTORE→PAUSE.
    - Else go to READ, or to WRITE in fill mode.
  - RESTORE: rdy=0, own=0 for one cycle. The CPU's held address is re-presented so its pending read data is valid when RDY rises.
  - PAUSE: rdy=1 for CPU_SLOTS cycles, then SYNC. An abort written here goes to DONE with aborted=1.
  - DONE: one cycle. Sets done, clears busy, then goes to IDLE.
- Arithmetic:
  - SRC/DST are 16-bit and wrap $FFFF→$0000.
  - LEN is 16-bit, and 0 means no transfer.
  - The burst counter is 8-bit and reloads on each SYNC.
- Reset mid-transfer: all state returns to IDLE immediately and rdy=1 the same edge. A partially copied block is left as is.

## Timing
- Reset values:
  - `cpu_rdy_o`=1, `bus_own_o`=0, `bus_we_o`=0, `bus_addr_o`=0, `bus_dout_o`=0, `dout_o`=0, `irq_o`=0.
  - All registers are 0.
- All outputs are registered or decoded from state registers. There is no combinational path from inputs to `cpu_rdy_o`/`bus_own_o`.
- Start written in cycle T: SYNC at T+1, first READ at T+2, first WRITE at T+3.
- Copy throughput is 2 cycles/byte. Fill throughput is 1 cycle/byte.
- Each burst costs 2 overhead cycles (SYNC and RESTORE) plus CPU_SLOTS.
- `bus_own_o` is never high while `cpu_rdy_o` is high.
- RESTORE always precedes any cycle with rdy=1 after ownership.
- Abort written during IDLE or DONE: no effect.
- Start written while busy: ignored.

## Structure
- Shared package `dma_pkg` holds:
  - register index constants (SRC_LO…FILL);
  - CTRL bit positions;
  - the state enum (IDLE, SYNC, READ, WRITE, RESTORE, PAUSE, DONE);
  - the base address nibble 4'b1010 for the top decoder.
- No sub-module. The register file and FSM are a single module.

## Test plan
- Copy SRC=$C000, DST=$8000, LEN=3, BURST_LEN=16 → VRAM gets ROM bytes 0–2. Start at T gives WRITEs at T+3, T+5, T+7. Then RESTORE, done=1, rdy high at T+9.
- Fill FILL=$20, DST=$8000, LEN=$1000 → 4096 bytes of $20, DST reads back $9000 and LEN reads back $0000. 256 bursts, each separated by exactly 4 rdy-high cycles.
- Copy with SRC=$FFFE, DST=$0100, LEN=4 → SRC wraps to $0002 and bytes come from $FFFE, $FFFF, $0000, $0001.
- Start with LEN=0 → done=1 after 2 cycles, no cycle with own=1, irq_o=1 if irq_en. CTRL read returns $0A, then irq_o=0.
- Abort written in PAUSE after burst 1 of a 40-byte copy → exactly 16 bytes written, status reads aborted=1 and done=1, LEN reads 24.
- `rst_i` pulsed during WRITE → next edge gives rdy=1, own=0, we=0, all registers 0. A CPU held in a write during SYNC keeps the bus until `cpu_we_i`=0.

Source files
------------

// File: rtl/dma_pkg.sv
// Shared definitions for the v65C02 DMA engine: register map, CTRL bits, FSM states.
package dma_pkg;

  localparam logic [2:0] RegSrcLo = 3'd0;
  localparam logic [2:0] RegSrcHi = 3'd1;
  localparam logic [2:0] RegDstLo = 3'd2;
  localparam logic [2:0] RegDstHi = 3'd3;
  localparam logic [2:0] RegLenLo = 3'd4;
  localparam logic [2:0] RegLenHi = 3'd5;
  localparam logic [2:0] RegCtrl  = 3'd6;
  localparam logic [2:0] RegFill  = 3'd7;

  // CTRL write bits
  localparam int unsigned CtrlStart = 0;
  localparam int unsigned CtrlFill  = 1;
  localparam int unsigned CtrlAbort = 2;
  localparam int unsigned CtrlIrqEn = 3;

  // CTRL read bits
  localparam int unsigned StatBusy    = 0;
  localparam int unsigned StatDone    = 1;
  localparam int unsigned StatAborted = 2;
  localparam int unsigned StatIrqEn   = 3;

  // Upper address nibble of the register window ($A000-$A007) for the top decoder
  localparam logic [3:0] DmaBaseNibble = 4'b1010;

  typedef enum logic [2:0] {
    StIdle,
    StSync,
    StRead,
    StWrite,
    StRestore,
    StPause,
    StDone
  } dma_state_e;

endpackage

// File: rtl/dma_ctrl.sv
// Memory-to-memory DMA engine: halts the 65C02 via RDY, copies or fills blocks in bursts,
// and hands the bus back for CPU_SLOTS cycles between bursts.
module dma_ctrl
  import dma_pkg::*;
#(
  parameter int unsigned BURST_LEN = 16,
  parameter int unsigned CPU_SLOTS = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        ctrl_en_i,
  input  logic        we_i,
  input  logic [2:0]  addr_i,
  input  logic [7:0]  din_i,
  output logic [7:0]  dout_o,
  input  logic        cpu_we_i,
  output logic        cpu_rdy_o,
  output logic        bus_own_o,
  output logic [15:0] bus_addr_o,
  output logic        bus_we_o,
  output logic [7:0]  bus_dout_o,
  input  logic [7:0]  bus_din_i,
  output logic        irq_o
);

  dma_state_e  r_state, w_state_next;
  logic [15:0] r_src, r_dst, r_len;
  logic [7:0]  r_fill, r_burst, r_slot;
  logic        r_fill_mode, r_irq_en, r_done, r_aborted;

  logic        w_busy, w_reg_wr, w_reg_rd, w_ctrl_wr, w_start, w_abort;
  logic [7:0]  w_burst_inc, w_rd_data, w_status;

  assign w_busy      = (r_state != StIdle);
  assign w_reg_wr    = ctrl_en_i & we_i;
  assign w_reg_rd    = ctrl_en_i & ~we_i;
  assign w_ctrl_wr   = w_reg_wr && (addr_i == RegCtrl);
  assign w_start     = w_ctrl_wr & din_i[CtrlStart];
  assign w_abort     = w_ctrl_wr & din_i[CtrlAbort];
  assign w_burst_inc = r_burst + 8'd1;

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      StIdle:    if (w_start) w_state_next = (r_len == 16'd0) ? StDone : StSync;
      // A CPU held mid-write just repeats it; wait for a read cycle before taking the bus
      StSync:    if (!cpu_we_i) w_state_next = r_fill_mode ? StWrite : StRead;
      StRead:    w_state_next = StWrite;
      StWrite: begin
        if (r_len == 16'd1 || w_burst_inc == 8'(BURST_LEN)) w_state_next = StRestore;
        else w_state_next = r_fill_mode ? StWrite : StRead;
      end
      StRestore: w_state_next = (r_len == 16'd0) ? StDone : StPause;
      StPause: begin
        if (w_abort) w_state_next = StDone;
        else if (r_slot == 8'(CPU_SLOTS - 1)) w_state_next = StSync;
      end
      StDone:    w_state_next = StIdle;
      default:   w_state_next = StIdle;
    endcase
  end

  always_comb begin
    w_status              = '0;
    w_status[StatBusy]    = w_busy;
    w_status[StatDone]    = r_done;
    w_status[StatAborted] = r_aborted;
    w_status[StatIrqEn]   = r_irq_en;
    case (addr_i)
      RegSrcLo: w_rd_data = r_src[7:0];
      RegSrcHi: w_rd_data = r_src[15:8];
      RegDstLo: w_rd_data = r_dst[7:0];
      RegDstHi: w_rd_data = r_dst[15:8];
      RegLenLo: w_rd_data = r_len[7:0];
      RegLenHi: w_rd_data = r_len[15:8];
      RegCtrl:  w_rd_data = w_status;
      default:  w_rd_data = r_fill;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state     <= StIdle;
      r_src       <= '0;
      r_dst       <= '0;
      r_len       <= '0;
      r_fill      <= '0;
      r_burst     <= '0;
      r_slot      <= '0;
      r_fill_mode <= 1'b0;
      r_irq_en    <= 1'b0;
      r_done      <= 1'b0;
      r_aborted   <= 1'b0;
      dout_o      <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_reg_wr && !w_busy) begin
        case (addr_i)
          RegSrcLo: r_src[7:0]  <= din_i;
          RegSrcHi: r_src[15:8] <= din_i;
          RegDstLo: r_dst[7:0]  <= din_i;
          RegDstHi: r_dst[15:8] <= din_i;
          RegLenLo: r_len[7:0]  <= din_i;
          RegLenHi: r_len[15:8] <= din_i;
          RegFill:  r_fill      <= din_i;
          default: ;
        endcase
      end
      if (w_reg_rd) dout_o <= w_rd_data;
      if ((w_reg_rd && addr_i == RegCtrl) || w_start) begin
        r_done    <= 1'b0;
        r_aborted <= 1'b0;
      end
      if (w_ctrl_wr) r_irq_en <= din_i[CtrlIrqEn];
      if (w_start && !w_busy) r_fill_mode <= din_i[CtrlFill];
      // Status sets come last so they win over a same-cycle clear
      case (r_state)
        StSync:    r_burst <= '0;
        StWrite: begin
          r_dst   <= r_dst + 16'd1;
          r_len   <= r_len - 16'd1;
          r_burst <= w_burst_inc;
          if (!r_fill_mode) r_src <= r_src + 16'd1;
        end
        StRestore: r_slot <= '0;
        StPause: begin
          r_slot <= r_slot + 8'd1;
          if (w_abort) r_aborted <= 1'b1;
        end
        StDone:    r_done <= 1'b1;
        default: ;
      endcase
    end
  end

  always_comb begin
    cpu_rdy_o  = (r_state == StIdle) || (r_state == StPause) || (r_state == StDone);
    bus_own_o  = (r_state == StRead) || (r_state == StWrite);
    bus_we_o   = (r_state == StWrite);
    bus_addr_o = '0;
    bus_dout_o = '0;
    if (r_state == StRead) bus_addr_o = r_src;
    if (r_state == StWrite) begin
      bus_addr_o = r_dst;
      bus_dout_o = r_fill_mode ? r_fill : bus_din_i;
    end
    irq_o = r_done & r_irq_en;
  end

endmodule

// File: tb/tb_dma_ctrl.sv
// Directed bench for dma_ctrl: bus writes scored against a queue filled at stimulus time.
module tb_dma_ctrl;
  import dma_pkg::*;

  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic        ctrl_en_i = 1'b0, we_i = 1'b0, cpu_we_i = 1'b0;
  logic [2:0]  addr_i = '0;
  logic [7:0]  din_i = '0, dout_o, bus_dout_o;
  logic [7:0]  bus_din_i = '0;
  logic        cpu_rdy_o, bus_own_o, bus_we_o, irq_o;
  logic [15:0] bus_addr_o;

  logic [23:0] sb[$];
  int          checks = 0, errors = 0;
  bit          mon_en = 1'b0;

  dma_ctrl #(.BURST_LEN(16), .CPU_SLOTS(4)) dut (
    .clk_i(clk), .rst_i(rst_i), .ctrl_en_i(ctrl_en_i), .we_i(we_i), .addr_i(addr_i),
    .din_i(din_i), .dout_o(dout_o), .cpu_we_i(cpu_we_i), .cpu_rdy_o(cpu_rdy_o),
    .bus_own_o(bus_own_o), .bus_addr_o(bus_addr_o), .bus_we_o(bus_we_o),
    .bus_dout_o(bus_dout_o), .bus_din_i(bus_din_i), .irq_o(irq_o)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] rom(input logic [15:0] a);
    return a[7:0] ^ a[15:8] ^ 8'h5A;
  endfunction

  // Pipelined read mux: data for the address presented in the previous cycle
  always @(posedge clk) bus_din_i <= rom(bus_addr_o);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      chk("own_while_rdy", 32'(bus_own_o & cpu_rdy_o), 0);
      if (bus_own_o && bus_we_o) begin
        chk("write_was_expected", 32'(sb.size() > 0), 1);
        if (sb.size() > 0) chk("write_addr_data", {8'h0, bus_addr_o, bus_dout_o}, 32'(sb.pop_front()));
      end
    end
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic wr_reg(input logic [2:0] a, input logic [7:0] d);
    ctrl_en_i = 1'b1; we_i = 1'b1; addr_i = a; din_i = d;
    step();
    ctrl_en_i = 1'b0; we_i = 1'b0;
  endtask

  task automatic rd_reg(input logic [2:0] a, output logic [7:0] d);
    ctrl_en_i = 1'b1; we_i = 1'b0; addr_i = a;
    step();
    d = dout_o;
    ctrl_en_i = 1'b0;
  endtask

  task automatic set_xfer(input logic [15:0] src, input logic [15:0] dst, input logic [15:0] len);
    wr_reg(RegSrcLo, src[7:0]); wr_reg(RegSrcHi, src[15:8]);
    wr_reg(RegDstLo, dst[7:0]); wr_reg(RegDstHi, dst[15:8]);
    wr_reg(RegLenLo, len[7:0]); wr_reg(RegLenHi, len[15:8]);
  endtask

  task automatic push_copy(input logic [15:0] src, input logic [15:0] dst, input int n);
    for (int i = 0; i < n; i++) sb.push_back({dst + 16'(i), rom(src + 16'(i))});
  endtask

  task automatic rd16(input logic [2:0] lo, output logic [15:0] v);
    logic [7:0] l, h;
    rd_reg(lo, l); rd_reg(lo + 3'd1, h);
    v = {h, l};
  endtask

  task automatic wait_irq(input string tag, input int budget);
    int n = 0;
    while (!irq_o && n < budget) begin step(); n++; end
    chk(tag, 32'(irq_o), 1);
  endtask

  initial begin
    logic [2:0]  exp_t1 [9] = '{3'b000, 3'b010, 3'b011, 3'b010, 3'b011,
                                3'b010, 3'b011, 3'b000, 3'b100};
    logic [7:0]  d;
    logic [15:0] v;
    int n, run, bursts, gaps, bad;
    bit seen, prev_own;

    repeat (2) step();
    rst_i = 1'b0;
    chk("reset_outputs", {cpu_rdy_o, bus_own_o, bus_we_o, irq_o, bus_addr_o, bus_dout_o, dout_o},
        {4'b1000, 16'h0, 8'h0, 8'h0});
    mon_en = 1'b1;

    // Short copy: cycle-accurate {rdy,own,we} from T+1 to T+9
    set_xfer(16'hC000, 16'h8000, 16'd3);
    push_copy(16'hC000, 16'h8000, 3);
    wr_reg(RegCtrl, 8'h09);
    for (int k = 0; k < 9; k++) begin
      chk($sformatf("copy3_timing_T%0d", k + 1), {29'h0, cpu_rdy_o, bus_own_o, bus_we_o},
          32'(exp_t1[k]));
      step();
    end
    chk("copy3_irq", 32'(irq_o), 1);
    rd_reg(RegCtrl, d); chk("copy3_status", 32'(d), 32'h0A);
    chk("copy3_irq_cleared", 32'(irq_o), 0);
    rd16(RegSrcLo, v); chk("copy3_src", 32'(v), 32'hC003);
    rd16(RegDstLo, v); chk("copy3_dst", 32'(v), 32'h8003);
    rd16(RegLenLo, v); chk("copy3_len", 32'(v), 0);
    chk("copy3_sb_drained", sb.size(), 0);

    // 4 KiB fill: 256 bursts separated by exactly CPU_SLOTS rdy-high cycles
    wr_reg(RegFill, 8'h20);
    set_xfer(16'h0000, 16'h8000, 16'h1000);
    for (int i = 0; i < 4096; i++) sb.push_back({16'h8000 + 16'(i), 8'h20});
    wr_reg(RegCtrl, 8'h0B);
    n = 0; run = 0; bursts = 0; gaps = 0; bad = 0; prev_own = 1'b0;
    while (!irq_o && n < 20000) begin
      if (bus_own_o && !prev_own) bursts++;
      if (cpu_rdy_o) run++;
      else begin
        if (run > 0) begin gaps++; if (run != 4) bad++; end
        run = 0;
      end
      prev_own = bus_own_o;
      step(); n++;
    end
    chk("fill_irq", 32'(irq_o), 1);
    chk("fill_bursts", bursts, 256);
    chk("fill_gaps", gaps, 255);
    chk("fill_bad_gaps", bad, 0);
    rd_reg(RegCtrl, d); chk("fill_status", 32'(d), 32'h0A);
    rd16(RegDstLo, v); chk("fill_dst", 32'(v), 32'h9000);
    rd16(RegLenLo, v); chk("fill_len", 32'(v), 0);
    chk("fill_sb_drained", sb.size(), 0);

    // Address wrap on source
    set_xfer(16'hFFFE, 16'h0100, 16'd4);
    push_copy(16'hFFFE, 16'h0100, 4);
    wr_reg(RegCtrl, 8'h09);
    wait_irq("wrap_irq", 100);
    rd_reg(RegCtrl, d); chk("wrap_status", 32'(d), 32'h0A);
    rd16(RegSrcLo, v); chk("wrap_src", 32'(v), 32'h0002);
    chk("wrap_sb_drained", sb.size(), 0);

    // LEN == 0 (left at zero by the previous transfer)
    wr_reg(RegCtrl, 8'h09);
    chk("len0_T1", {30'h0, cpu_rdy_o, irq_o}, 32'b10);
    step();
    chk("len0_T2_irq", 32'(irq_o), 1);
    rd_reg(RegCtrl, d); chk("len0_status", 32'(d), 32'h0A);
    chk("len0_irq_cleared", 32'(irq_o), 0);

    // Abort in the first pause of a 40-byte copy
    set_xfer(16'hC100, 16'h8100, 16'd40);
    push_copy(16'hC100, 16'h8100, 16);
    wr_reg(RegCtrl, 8'h09);
    n = 0; seen = 1'b0;
    while (!(seen && cpu_rdy_o) && n < 200) begin
      if (bus_own_o) seen = 1'b1;
      step(); n++;
    end
    chk("abort_pause_reached", 32'(seen && cpu_rdy_o), 1);
    wr_reg(RegCtrl, 8'h0C);
    wait_irq("abort_irq", 20);
    rd_reg(RegCtrl, d); chk("abort_status", 32'(d), 32'h0E);
    rd16(RegLenLo, v); chk("abort_len", 32'(v), 24);
    chk("abort_sb_drained", sb.size(), 0);

    // Reset pulsed during the first WRITE
    set_xfer(16'hC200, 16'h8300, 16'd40);
    push_copy(16'hC200, 16'h8300, 1);
    wr_reg(RegCtrl, 8'h09);
    n = 0;
    while (!(bus_own_o && bus_we_o) && n < 10) begin step(); n++; end
    chk("rst_write_reached", 32'(bus_own_o && bus_we_o), 1);
    rst_i = 1'b1;
    step();
    chk("rst_outputs", {cpu_rdy_o, bus_own_o, bus_we_o, irq_o, bus_addr_o, dout_o},
        {4'b1000, 16'h0, 8'h0});
    rst_i = 1'b0;
    for (int a = 0; a < 8; a++) begin
      rd_reg(3'(a), d);
      chk($sformatf("rst_reg%0d", a), 32'(d), 0);
    end
    chk("rst_sb_drained", sb.size(), 0);

    // CPU held in a write keeps the bus through SYNC
    set_xfer(16'hC010, 16'h8400, 16'd1);
    push_copy(16'hC010, 16'h8400, 1);
    cpu_we_i = 1'b1;
    wr_reg(RegCtrl, 8'h09);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("hold_sync%0d", k), {30'h0, cpu_rdy_o, bus_own_o}, 0);
      step();
    end
    cpu_we_i = 1'b0;
    step();
    chk("hold_read", {15'h0, bus_own_o, bus_we_o, bus_addr_o}, {15'h0, 2'b10, 16'hC010});
    wait_irq("hold_irq", 20);
    rd_reg(RegCtrl, d); chk("hold_status", 32'(d), 32'h0A);
    chk("hold_sb_drained", sb.size(), 0);

    mon_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
